// File: rtl/uart_tx_sched_if.sv
// Requester and frame-engine signals of the UART transmit scheduler.
// The master side drives requests and frame-ready; the slave side is the scheduler.
interface uart_tx_sched_if;
  logic        sched_en;
  logic [3:0]  req;
  logic [71:0] req_data;
  logic [3:0]  grant;
  logic        frm_valid;
  logic [5:0]  frm_data;
  logic        frm_ready;
  logic        busy;
  logic [15:0] word_cnt;

  modport master (
    output sched_en, req, req_data, frm_ready,
    input  grant, frm_valid, frm_data, busy, word_cnt
  );

  modport slave (
    input  sched_en, req, req_data, frm_ready,
    output grant, frm_valid, frm_data, busy, word_cnt
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler: grants one of four 18-bit words, sends it as a header
// frame plus three 6-bit data frames, then holds the line idle for GAP_CLKS cycles.
module uart_tx_sched #(
  parameter int GAP_CLKS = 166656
) (
  input  logic           sys_clk,
  input  logic           sys_reset,
  uart_tx_sched_if.slave bus
);

  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_D0,
    S_D1,
    S_D2,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [17:0]      r_word, w_word_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic             r_frm_valid, w_frm_valid_nxt;
  logic [5:0]       r_frm_data, w_frm_data_nxt;
  logic [15:0]      r_word_cnt, w_word_cnt_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

  logic             w_xfer;
  logic             w_win_found;
  logic [1:0]       w_win_idx;
  logic [17:0]      w_win_word;

  // Returns {found, index}: first set request at or above ptr, wrapping 3->0.
  function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      k = ptr + 2'(i);
      if (!res[2] && req[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign w_xfer                   = r_frm_valid & bus.frm_ready;
  assign {w_win_found, w_win_idx} = pick_winner(bus.req, r_ptr);

  always_comb begin
    w_win_word = bus.req_data[17:0];
    case (w_win_idx)
      2'd0: w_win_word = bus.req_data[17:0];
      2'd1: w_win_word = bus.req_data[35:18];
      2'd2: w_win_word = bus.req_data[53:36];
      2'd3: w_win_word = bus.req_data[71:54];
      default: w_win_word = bus.req_data[17:0];
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_word      <= '0;
      r_grant     <= '0;
      r_frm_valid <= 1'b0;
      r_frm_data  <= '0;
      r_word_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_word      <= w_word_nxt;
      r_grant     <= w_grant_nxt;
      r_frm_valid <= w_frm_valid_nxt;
      r_frm_data  <= w_frm_data_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  // Outputs are registered, so each branch sets the frame seen in the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_word_nxt      = r_word;
    w_grant_nxt     = '0;
    w_frm_valid_nxt = r_frm_valid;
    w_frm_data_nxt  = r_frm_data;
    w_word_cnt_nxt  = r_word_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.sched_en && w_win_found) begin
          w_state_nxt     = S_HDR;
          w_grant_nxt     = 4'b0001 << w_win_idx;
          w_ptr_nxt       = w_win_idx + 2'd1;
          w_word_nxt      = w_win_word;
          w_frm_valid_nxt = 1'b1;
          w_frm_data_nxt  = {4'b1010, w_win_idx};
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_state_nxt    = S_D0;
          w_frm_data_nxt = r_word[5:0];
        end
      end
      S_D0: begin
        if (w_xfer) begin
          w_state_nxt    = S_D1;
          w_frm_data_nxt = r_word[11:6];
        end
      end
      S_D1: begin
        if (w_xfer) begin
          w_state_nxt    = S_D2;
          w_frm_data_nxt = r_word[17:12];
        end
      end
      S_D2: begin
        if (w_xfer) begin
          w_frm_valid_nxt = 1'b0;
          w_word_cnt_nxt  = r_word_cnt + 16'd1;
          w_gap_cnt_nxt   = '0;
          w_state_nxt     = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = S_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.grant     = r_grant;
  assign bus.frm_valid = r_frm_valid;
  assign bus.frm_data  = r_frm_data;
  assign bus.word_cnt  = r_word_cnt;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with GAP_CLKS=4: cycle vector table for
// single words with and without backpressure, plus arbitration/enable/reset sequences.
module tb_uart_tx_sched;
  localparam int GAP = 4;

  logic sys_clk = 1'b0;
  logic sys_reset = 1'b0;

  uart_tx_sched_if bus();

  uart_tx_sched #(.GAP_CLKS(GAP)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [17:0] data;
    logic        rdy;
    logic [3:0]  g;
    logic        v;
    logic [5:0]  d;
    logic        b;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [17:0] W1 = 18'h2B3C5;
  localparam logic [17:0] W2 = 18'h1E4A7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic add(input logic en, input logic [3:0] req, input logic [17:0] data,
                     input logic rdy, input logic [3:0] g, input logic v,
                     input logic [5:0] d, input logic b, input logic [15:0] c);
    vec_t e;
    e.en = en; e.req = req; e.data = data; e.rdy = rdy;
    e.g = g; e.v = v; e.d = d; e.b = b; e.c = c;
    tbl.push_back(e);
  endtask

  task automatic do_reset;
    bus.sched_en  = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.frm_ready = 1'b0;
    sys_reset = 1'b0;
    tick;
    tick;
    sys_reset = 1'b1;
  endtask

  logic [5:0] w2_frames [3];

  initial begin
    int last_cyc;
    int found;
    int gcount;

    // Word 1 at full rate: header 0x28, then 0x05, 0x0F, 0x2B, 4 gap cycles, idle.
    add(1, 4'h1, W1, 1, 4'h1, 1, 6'h28, 1, 16'd0);
    add(1, 4'h0, W1, 1, 4'h0, 1, 6'h05, 1, 16'd0);
    add(1, 4'h0, W1, 1, 4'h0, 1, 6'h0F, 1, 16'd0);
    add(1, 4'h0, W1, 1, 4'h0, 1, 6'h2B, 1, 16'd0);
    for (int i = 0; i < GAP; i++) add(1, 4'h0, W1, 1, 4'h0, 0, 6'h00, 1, 16'd1);
    add(1, 4'h0, W1, 1, 4'h0, 0, 6'h00, 0, 16'd1);
    // Word 2 with ready low 3 cycles per frame; req dropped and data scrambled after capture.
    w2_frames[0] = 6'h27;
    w2_frames[1] = 6'h12;
    w2_frames[2] = 6'h1E;
    add(1, 4'h1, W2, 0, 4'h1, 1, 6'h28, 1, 16'd1);
    for (int i = 0; i < 3; i++) add(1, 4'h0, 18'h3FFFF, 0, 4'h0, 1, 6'h28, 1, 16'd1);
    for (int f = 0; f < 3; f++) begin
      add(1, 4'h0, 18'h3FFFF, 1, 4'h0, 1, w2_frames[f], 1, 16'd1);
      for (int i = 0; i < 3; i++) add(1, 4'h0, 18'h00000, 0, 4'h0, 1, w2_frames[f], 1, 16'd1);
    end
    add(1, 4'h0, 18'h3FFFF, 1, 4'h0, 0, 6'h00, 1, 16'd2);
    for (int i = 1; i < GAP; i++) add(1, 4'h0, 18'h3FFFF, 1, 4'h0, 0, 6'h00, 1, 16'd2);
    add(1, 4'h0, 18'h3FFFF, 1, 4'h0, 0, 6'h00, 0, 16'd2);

    // Reset state
    bus.sched_en  = 1'b1;
    bus.req       = 4'hF;
    bus.req_data  = '1;
    bus.frm_ready = 1'b1;
    tick;
    tick;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.frm_valid), 32'd0);
    chk("rst_data", 32'(bus.frm_data), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_cnt", 32'(bus.word_cnt), 32'd0);
    do_reset;

    foreach (tbl[i]) begin
      bus.sched_en       = tbl[i].en;
      bus.req            = tbl[i].req;
      bus.req_data[17:0] = tbl[i].data;
      bus.frm_ready      = tbl[i].rdy;
      tick;
      chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
      chk($sformatf("v%0d_valid", i), 32'(bus.frm_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("v%0d_data", i), 32'(bus.frm_data), 32'(tbl[i].d));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].b));
      chk($sformatf("v%0d_cnt", i), 32'(bus.word_cnt), 32'(tbl[i].c));
    end

    // Round robin with all four requesting, plus grant spacing
    do_reset;
    bus.sched_en  = 1'b1;
    bus.req       = 4'hF;
    bus.req_data  = 72'h0123456789ABCDEF01;
    bus.frm_ready = 1'b1;
    last_cyc = 0;
    for (int w = 0; w < 5; w++) begin
      found = 0;
      for (int n = 0; n < 30; n++) begin
        tick;
        if (bus.grant != 4'h0) begin
          found = 1;
          break;
        end
      end
      chk($sformatf("rr%0d_found", w), 32'(found), 32'd1);
      chk($sformatf("rr%0d_grant", w), 32'(bus.grant), 32'(4'b0001 << (w % 4)));
      chk($sformatf("rr%0d_hdr", w), 32'(bus.frm_data), 32'(6'h28 + (w % 4)));
      if (w > 0) chk($sformatf("rr%0d_spacing", w), 32'(cyc - last_cyc), 32'(4 + GAP + 1));
      last_cyc = cyc;
    end

    // sched_en dropped during D1
    do_reset;
    bus.sched_en  = 1'b1;
    bus.req       = 4'b0010;
    bus.req_data  = 72'h0;
    bus.req_data[35:18] = W1;
    bus.frm_ready = 1'b1;
    tick;
    chk("en_grant0", 32'(bus.grant), 32'h2);
    chk("en_hdr", 32'(bus.frm_data), 32'h29);
    tick;
    tick;
    chk("en_d1", 32'(bus.frm_data), 32'h0F);
    bus.sched_en = 1'b0;
    gcount = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (bus.grant != 4'h0) gcount++;
    end
    chk("en_nogrant", 32'(gcount), 32'd0);
    chk("en_idle", 32'(bus.busy), 32'd0);
    chk("en_cnt", 32'(bus.word_cnt), 32'd1);
    bus.sched_en = 1'b1;
    tick;
    chk("en_regrant", 32'(bus.grant), 32'h2);

    // Asynchronous reset in D0
    tick;
    chk("ar_in_d0", 32'(bus.frm_data), 32'h05);
    #2;
    sys_reset = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.frm_valid), 32'd0);
    chk("ar_cnt", 32'(bus.word_cnt), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_data", 32'(bus.frm_data), 32'd0);
    bus.req = 4'b1100;
    tick;
    chk("ar_held", 32'(bus.grant), 32'd0);
    sys_reset = 1'b1;
    tick;
    chk("ar_grant", 32'(bus.grant), 32'h4);
    chk("ar_hdr", 32'(bus.frm_data), 32'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CLKS, default 166656, meaning idle sys_clk cycles after each word (8 bit times at 20832 clk/bit).
REQ-002 sys_clk  input  1  system clock; all state on rising edge.
REQ-003 sys_reset  input  1  reset, asynchronous, active-low.
REQ-004 sched_en  input  1  scheduler enable; low blocks new grants only.
REQ-005 req  input  4  per-requester word-pending request, level.
REQ-006 req_data  input  72  four 18-bit words; requester k on bits [18k+17:18k].
REQ-007 grant  output  4  one-hot, one-cycle pulse: word of that requester captured.
REQ-008 frm_valid  output  1  6-bit frame offered to the UART frame engine.
REQ-009 frm_data  output  6  frame payload, LSB first on line.
REQ-010 frm_ready  input  1  engine accepts frame; transfer = frm_valid & frm_ready at an edge.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 word_cnt  output  16  count of completed words, wraps 0xFFFF->0x0000.

Function
REQ-013 States IDLE, HDR, D0, D1, D2, GAP; busy = (state != IDLE).
REQ-014 IDLE, sched_en=1, req!=0: next edge selects winner, captures its 18-bit word, pulses grant, enters HDR with frm_valid=1, frm_data={4'b1010, winner[1:0]}.
REQ-015 Winner = first set req bit scanning upward from priority pointer ptr, wrapping 3->0.
REQ-016 ptr resets to 0; on each grant to k, ptr <= (k+1) mod 4.
REQ-017 Captured word held internally; req/req_data changes after capture have no effect on the word in flight.
REQ-018 HDR transfer -> D0, frm_data=word[5:0]; D0 transfer -> D1, word[11:6]; D1 transfer -> D2, word[17:12]; frm_valid stays 1 across these edges.
REQ-019 frm_valid/frm_data hold stable while frm_valid=1 and frm_ready=0; no timeout.
REQ-020 D2 transfer: frm_valid<=0, word_cnt increments, enter GAP with gap counter 0; if GAP_CLKS=0 enter IDLE directly.
REQ-021 GAP: counter increments each cycle; at count GAP_CLKS-1 next state IDLE; frm_valid=0 throughout.
REQ-022 frm_ready ignored while frm_valid=0.
REQ-023 sched_en=0 mid-word: current word and gap complete; no further grant until sched_en=1 in IDLE.
REQ-024 grant is 0 in every cycle except the first HDR cycle; at most one grant per word.
REQ-025 Minimum spacing between grants: 4 transfer cycles + GAP_CLKS + 1 IDLE cycle.

Reset
REQ-026 sys_reset=0 asynchronously forces: state IDLE, frm_valid=0, frm_data=0, grant=0, busy=0, word_cnt=0, ptr=0, gap counter 0, captured word 0.
REQ-027 Reset mid-word abandons the word without incrementing word_cnt; first post-release grant follows REQ-014/015 with ptr=0.

Verification (GAP_CLKS=4)
REQ-028 req=4'b0001, req_data[17:0]=18'h2B3C5, frm_ready=1 -> grant=0001 one cycle; frames 0x28, 0x05, 0x0F, 0x2B on consecutive cycles; word_cnt=1; busy low 5 cycles after last frame.
REQ-029 req=4'b1111 held, frm_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001; headers 0x28, 0x29, 0x2A, 0x2B.
REQ-030 Single word, frm_ready low 3 cycles on each frame -> each frame held stable 4 cycles, no frame lost/duplicated, word_cnt=1.
REQ-031 sched_en dropped during D1 with req=4'b0010 held -> word completes, then state IDLE, no grant until sched_en=1, then grant=0010 next cycle.
REQ-032 sys_reset asserted in D0 -> frm_valid=0, word_cnt=0 immediately; after release with req=4'b1100 -> grant=0100.
REQ-033 req toggled low after grant, req_data changed during HDR -> transmitted frames carry originally captured word.
